adder_op_sequencer: RTL
=======================

// Module: adder_op_sequencer
// PURPOSE
//  Sequences operand entry for the 3-bit board adder using a single "enter" pushbutton.
//  The user keys A on sw[2:0] and presses. Then B on sw[5:3] and presses. The block latches
//  both operands, computes the 4-bit sum and holds the result on the LEDs. The next press
//  restarts the cycle. It sits between the board switches/button and the LED bank.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable clk cycles before btn changes state (10 ms @ 50 MHz); must be >= 2
//  CNT_W            20      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk   in   1  board clock; the only clock
//  rst   in   1  synchronous, active-high reset
//  btn   in   1  raw "enter" pushbutton; asynchronous and bouncy
//  sw    in   8  [2:0] operand A, [5:3] operand B, [7] display select in RESULT; sw[6] unused
//  led   out  8  registered display, encoding below
// BEHAVIOUR
//  Reset:
//   - While rst=1 at a clk edge: led<=8'h00, state<=S_A, a_reg=b_reg=3'b0, sum_reg=4'b0.
//   - Debouncer state is cleared in the same way: sync FFs=0, stable=0, counter=0.
//   - rst mid-operation aborts entry. Nothing already latched survives.
//  Debounce (sub-module):
//   - btn passes through a 2-FF synchroniser.
//   - The counter increments on every cycle where sync != stable and clears on any cycle
//     where sync == stable.
//   - When the counter reaches DEBOUNCE_CYCLES-1 and the mismatch persists, stable<=sync
//     and counter<=0.
//   - press = stable & ~stable_d. It is a one-cycle pulse on the 0->1 transition only;
//     release generates no event.
//   - Latency: with a clean btn rise, the FSM transition occurs on the (DEBOUNCE_CYCLES+3)th
//     rising clk edge after btn goes high.
//   - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no press.
//   - A btn held across reset release yields exactly one press after the debounce latency.
//  FSM: states S_A, S_B, S_RES. Transitions happen only on press.
//   - S_A --press--> S_B: a_reg<=sw[2:0].
//   - S_B --press--> S_RES: b_reg<=sw[5:3] and sum_reg<=a_reg+sw[5:3], a 4-bit
//     zero-extended add that cannot overflow (max 7+7=14).
//   - S_RES --press--> S_A: the registers keep their values until overwritten.
//   - sw is sampled directly, without synchronisation, on the transition edge. It is treated
//     as quasi-static.
//  led: registered, updated every cycle, so it shows sw changes with one cycle of latency.
//   - S_A:   {2'b01, 3'b000, sw[2:0]}  (live preview of A)
//   - S_B:   {2'b10, a_reg, sw[5:3]}   (latched A, live preview of B)
//   - S_RES: sw[7]=0 -> {2'b11, 2'b00, sum_reg}; sw[7]=1 -> {2'b00, b_reg, a_reg}
//  led on the transition cycle: on the edge where state changes, led is computed from the
//  OLD state. The new encoding appears one edge later.
// STRUCTURE
//  - Package adder_seq_pkg holds:
//    - the state encodings S_A=2'b01, S_B=2'b10 and S_RES=2'b11, which double as led[7:6] tags;
//    - the operand width OP_W=3;
//    - the sum width SUM_W=4.
//  - Sub-module btn_debounce (clk, rst, btn_raw, press) with parameters DEBOUNCE_CYCLES and
//    CNT_W. It holds the synchroniser, counter and edge detector.
//  - The top level holds the FSM, the operand and sum registers, and the led mux/register.
// TESTING  (DEBOUNCE_CYCLES=4, CNT_W=3, clean presses held 10 cycles unless noted)
//  1. rst=1 for 2 cycles with sw=8'h05 -> led=8'h00 during reset. After rst drops,
//     led=8'h45 from the first edge onward.
//  2. Press with sw[2:0]=5, then set sw[5:3]=6 -> led=8'hAE. Press again -> led=8'hCB (sum 11).
//     FSM edge lands exactly 7 edges after btn rises.
//  3. In S_RES with a=5, b=6, set sw[7]=1 -> led=8'h35. Clear sw[7] -> led=8'hCB.
//     A further press returns to S_A -> led=8'h4x (x=sw[2:0]).
//  4. A=7, B=7 -> led=8'hCE. Also A=0, B=0 -> led=8'hC0.
//  5. Bounce: btn pulses of 1, 2 and 3 cycles separated by 1-cycle lows -> no state change.
//     Then btn held 4+ cycles -> exactly one transition. Holding btn 100 cycles -> still one.
//  6. Assert rst for 1 cycle while in S_B with A latched -> led=8'h00, then S_A preview.
//     a_reg=0 on a read-back via the sw[7]=1 view after a full cycle with B=0 (led=8'h00).

Source files
------------

// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq_pkg
//  Description : Shared widths and state encodings for the operand sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

   localparam int OP_W  = 3;
   localparam int SUM_W = 4;

   // Encodings double as the led[7:6] tag of each display mode.
   typedef enum logic [1:0] {
      S_A   = 2'b01,
      S_B   = 2'b10,
      S_RES = 2'b11
   } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Synchronises and debounces a raw pushbutton; one-cycle press pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_d;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync1    <= btn_raw;
         r_sync2    <= r_sync1;
         r_stable_d <= r_stable;
         // Any cycle of agreement restarts the stability window.
         if (r_sync2 != r_stable) begin
            if (r_cnt == c_cnt_max) begin
               r_stable <= r_sync2;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign press = r_stable & ~r_stable_d;

endmodule
`default_nettype wire

// File: rtl/adder_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adder_op_sequencer
//  Description : Single-button operand entry for the 3-bit adder, result on LEDs.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_op_sequencer
   import adder_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   input  logic [7:0] sw,
   output logic [7:0] led
);

   state_t            r_state;
   state_t            w_state_next;
   logic              w_press;
   logic [OP_W-1:0]   r_a_reg;
   logic [OP_W-1:0]   r_b_reg;
   logic [SUM_W-1:0]  r_sum_reg;
   logic [7:0]        r_led;
   logic [7:0]        w_led_next;
   logic              w_unused;

   assign w_unused = sw[6];

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn),
      .press   (w_press)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_A;
         r_a_reg   <= '0;
         r_b_reg   <= '0;
         r_sum_reg <= '0;
         r_led     <= 8'h00;
      end else begin
         r_state <= w_state_next;
         r_led   <= w_led_next;
         if (w_press) begin
            case (r_state)
               S_A: r_a_reg <= sw[2:0];
               S_B: begin
                  r_b_reg   <= sw[5:3];
                  r_sum_reg <= SUM_W'(r_a_reg) + SUM_W'(sw[5:3]);
               end
               default: ;
            endcase
         end
      end
   end

   // The display is derived from the current state, so a transition shows up one edge late.
   always_comb begin
      w_state_next = r_state;
      w_led_next   = 8'h00;
      case (r_state)
         S_A: begin
            if (w_press) w_state_next = S_B;
            w_led_next = {S_A, 3'b000, sw[2:0]};
         end
         S_B: begin
            if (w_press) w_state_next = S_RES;
            w_led_next = {S_B, r_a_reg, sw[5:3]};
         end
         S_RES: begin
            if (w_press) w_state_next = S_A;
            w_led_next = sw[7] ? {2'b00, r_b_reg, r_a_reg}
                               : {S_RES, 2'b00, r_sum_reg};
         end
         default: begin
            w_state_next = S_A;
            w_led_next   = 8'h00;
         end
      endcase
   end

   assign led = r_led;

endmodule
`default_nettype wire
